// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner sequencer for a shared tristate net.
// Drives the active-low bufif0 enables so that at most one driver is on,
// inserts TURN all-highz cycles between owners and caps ownership at HOLD_MAX
// cycles while another requester is waiting.
//
// Handshake: req[i] is a level request, held by the requester until it is
// done with the bus; gnt[i] (== ~oe_n[i]) is asserted from the edge that
// sampled req[i] high until the edge that sees req[i] low or hold expiry.
// There is no ready/valid back-pressure: a requester simply waits for gnt.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int TURN     = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N-1:0]                       req,
  output logic [N-1:0]                       oe_n,
  output logic [N-1:0]                       gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
  output logic                               bus_idle,
  output logic [1:0]                         dbg_state
);

  localparam int IDW      = (N > 1) ? $clog2(N) : 1;
  localparam int HW       = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int HOLD_SAT = (HOLD_MAX > 0) ? HOLD_MAX : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [3:0]     turn_q, turn_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic [IDW-1:0] owner_inc;
  logic [IDW-1:0] arb_start;
  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  logic [2*N-1:0] req_rot;
  logic           expire;

  // Pointer just past the current owner, wrapping N-1 -> 0.
  always_comb begin
    owner_inc = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
  end

  // An exiting owner searches from the slot after itself; otherwise from ptr.
  assign arb_start = (state_q == ST_OWN) ? owner_inc : ptr_q;

  // Round-robin search: first set request at or above arb_start, wrapping.
  always_comb begin
    logic [IDW:0] pos;
    arb_found = 1'b0;
    arb_idx   = '0;
    pos       = '0;
    req_rot   = {req, req} >> arb_start;
    for (int i = 0; i < N; i++) begin
      if (!arb_found && req_rot[i]) begin
        arb_found = 1'b1;
        pos       = {1'b0, arb_start} + (IDW + 1)'(i);
        if (pos >= (IDW + 1)'(N)) begin
          pos = pos - (IDW + 1)'(N);
        end
        arb_idx = pos[IDW-1:0];
      end
    end
  end

  // Hold expiry only matters when somebody else is waiting for the bus.
  assign expire = (HOLD_MAX != 0) && (hold_q == HW'(HOLD_SAT)) && (|(req & ~gnt_q));

  // Next-state, grant and counter logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    turn_d  = turn_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (arb_found) begin
          state_d = ST_OWN;
          gnt_d   = N'(1) << arb_idx;
          owner_d = arb_idx;
          hold_d  = HW'(1);
        end
      end
      ST_OWN: begin
        if (!req[owner_q] || expire) begin
          ptr_d = owner_inc;
          gnt_d = '0;
          if (TURN > 0) begin
            state_d = ST_TURN;
            turn_d  = 4'(TURN);
          end else if (arb_found) begin
            state_d = ST_OWN;
            gnt_d   = N'(1) << arb_idx;
            owner_d = arb_idx;
            hold_d  = HW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hold_q < HW'(HOLD_SAT)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_TURN: begin
        gnt_d = '0;
        if (turn_q <= 4'd1) begin
          turn_d = '0;
          if (arb_found) begin
            state_d = ST_OWN;
            gnt_d   = N'(1) << arb_idx;
            owner_d = arb_idx;
            hold_d  = HW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset releases the shared net immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      turn_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      turn_q  <= turn_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign oe_n      = ~gnt_q;
  assign bus_idle  = ~(|gnt_q);
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed vector table, hand-written multi-cycle
// sequences on three parameterisations, and a randomized run with a
// behavioural owner model plus real bufif0 drivers on one shared wire.
module tb_tri_bus_arbiter;

  localparam int N     = 4;
  localparam int TN    = 1;
  localparam int HM    = 8;
  localparam int BOUND = 3 * (HM + TN + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [3:0] req_a, req_h, req_t;
  logic [3:0] oe_n_a, oe_n_h, oe_n_t;
  logic [3:0] gnt_a, gnt_h, gnt_t;
  logic [1:0] owner_a, owner_h, owner_t;
  logic       idle_a, idle_h, idle_t;
  logic [1:0] dbg_a, dbg_h, dbg_t;

  tri_bus_arbiter #(.N(N), .TURN(TN), .HOLD_MAX(HM)) u_dut (
    .clk(clk), .rst(rst), .req(req_a), .oe_n(oe_n_a), .gnt(gnt_a),
    .owner(owner_a), .bus_idle(idle_a), .dbg_state(dbg_a));

  tri_bus_arbiter #(.N(N), .TURN(TN), .HOLD_MAX(0)) u_dut_h0 (
    .clk(clk), .rst(rst), .req(req_h), .oe_n(oe_n_h), .gnt(gnt_h),
    .owner(owner_h), .bus_idle(idle_h), .dbg_state(dbg_h));

  tri_bus_arbiter #(.N(N), .TURN(0), .HOLD_MAX(HM)) u_dut_t0 (
    .clk(clk), .rst(rst), .req(req_t), .oe_n(oe_n_t), .gnt(gnt_t),
    .owner(owner_t), .bus_idle(idle_t), .dbg_state(dbg_t));

  // Shared net: driver i sources its index parity.
  wire        bus;
  logic [3:0] src;
  assign src = 4'b1010;
  for (genvar gi = 0; gi < 4; gi++) begin : g_drv
    bufif0 u_drv (bus, src[gi], oe_n_a[gi]);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Invariants on every DUT every cycle, plus the value on the wire.
  always @(negedge clk) begin
    chk("inv_oe_a", 32'(oe_n_a), 32'(4'(~gnt_a)));
    chk("inv_idle_a", 32'(idle_a), 32'(&oe_n_a));
    chk("inv_onehot_a", 32'($onehot0(gnt_a)), 32'd1);
    chk("inv_oe_h", 32'(oe_n_h), 32'(4'(~gnt_h)));
    chk("inv_idle_h", 32'(idle_h), 32'(&oe_n_h));
    chk("inv_onehot_h", 32'($onehot0(gnt_h)), 32'd1);
    chk("inv_oe_t", 32'(oe_n_t), 32'(4'(~gnt_t)));
    chk("inv_idle_t", 32'(idle_t), 32'(&oe_n_t));
    chk("inv_onehot_t", 32'($onehot0(gnt_t)), 32'd1);
    if (gnt_a != 4'b0000) begin
      chk("bus_wire", {31'd0, bus}, {31'd0, owner_a[0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst   = 1'b1;
    req_a = '0;
    req_h = '0;
    req_t = '0;
    #1;
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_oe_n", 32'(oe_n_a), 32'hf);
    chk("rst_owner", 32'(owner_a), 32'd0);
    chk("rst_idle", 32'(idle_a), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- behavioural model (random phase) ----------------
  int m_owner, m_hold, m_gap, m_ptr;

  function automatic int rr_pick(input logic [3:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // Advances the model across one clock edge with r sampled at that edge.
  task automatic model_step(input logic [3:0] r);
    bit do_pick;
    logic [3:0] others;
    do_pick = 1'b0;
    if (m_owner >= 0) begin
      others = r & ~(4'b0001 << m_owner);
      if (!r[m_owner] || (HM != 0 && m_hold >= HM && others != 4'b0000)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        if (TN > 0) m_gap = TN;
        else do_pick = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) do_pick = 1'b1;
    end else begin
      do_pick = 1'b1;
    end
    if (do_pick) begin
      m_owner = rr_pick(r, m_ptr);
      m_hold  = 1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    int         own;
  } vec_t;

  vec_t vecs [22];

  initial begin
    // Watchdog: the whole run is far below this.
    #600000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] e;
    int wait_cnt [4];

    vecs[0]  = '{4'b0000, 4'b0000, 0};
    vecs[1]  = '{4'b0101, 4'b0001, 0};
    vecs[2]  = '{4'b0101, 4'b0001, 0};
    vecs[3]  = '{4'b0101, 4'b0001, 0};
    vecs[4]  = '{4'b0100, 4'b0000, 0};
    vecs[5]  = '{4'b0100, 4'b0100, 2};
    vecs[6]  = '{4'b0100, 4'b0100, 2};
    vecs[7]  = '{4'b0000, 4'b0000, 0};
    vecs[8]  = '{4'b0000, 4'b0000, 0};
    vecs[9]  = '{4'b0001, 4'b0001, 0};
    vecs[10] = '{4'b0001, 4'b0001, 0};
    vecs[11] = '{4'b1001, 4'b0001, 0};
    vecs[12] = '{4'b1000, 4'b0000, 0};
    vecs[13] = '{4'b1000, 4'b1000, 3};
    vecs[14] = '{4'b0000, 4'b0000, 0};
    vecs[15] = '{4'b0010, 4'b0010, 1};
    vecs[16] = '{4'b0001, 4'b0000, 0};
    vecs[17] = '{4'b0000, 4'b0000, 0};
    vecs[18] = '{4'b0000, 4'b0000, 0};
    vecs[19] = '{4'b0011, 4'b0001, 0};
    vecs[20] = '{4'b0000, 4'b0000, 0};
    vecs[21] = '{4'b0000, 4'b0000, 0};

    req_a = '0;
    req_h = '0;
    req_t = '0;
    do_reset();

    // Table: basic grant, TURN gap, wrap-around search, late requesters.
    for (int v = 0; v < 22; v++) begin
      req_a = vecs[v].req;
      tick();
      chk($sformatf("vec%0d_gnt", v), 32'(gnt_a), 32'(vecs[v].gnt));
      if (vecs[v].gnt != 4'b0000) begin
        chk($sformatf("vec%0d_owner", v), 32'(owner_a), 32'(vecs[v].own));
      end
    end

    // Two requesters held: hold limit alternates owners; HOLD_MAX=0 never yields.
    do_reset();
    req_a = 4'b0011;
    req_h = 4'b0011;
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int c = 0; c < HM; c++) begin
        tick();
        chk("hold_own", 32'(gnt_a), 32'(4'b0001 << (rnd % 2)));
        chk("hold0_own", 32'(gnt_h), 32'd1);
      end
      tick();
      chk("hold_turn", 32'(gnt_a), 32'd0);
      chk("hold0_own", 32'(gnt_h), 32'd1);
    end

    // All four held: order 0,1,2,3,0 with one idle cycle between owners.
    do_reset();
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < HM; c++) begin
        tick();
        chk("rr_gnt", 32'(gnt_a), 32'(4'b0001 << (k % 4)));
        chk("rr_owner", 32'(owner_a), 32'(k % 4));
      end
      tick();
      chk("rr_gap", 32'(gnt_a), 32'd0);
    end

    // Same with no turnaround: back-to-back handover.
    do_reset();
    req_t = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < HM; c++) begin
        tick();
        chk("t0_gnt", 32'(gnt_t), 32'(4'b0001 << (k % 4)));
      end
    end

    // Asynchronous reset in the middle of ownership.
    do_reset();
    req_a = 4'b0001;
    tick();
    chk("ar_own0", 32'(gnt_a), 32'd1);
    req_a = 4'b0000;
    tick();
    tick();
    req_a = 4'b0011;
    tick();
    chk("ar_own1", 32'(gnt_a), 32'b0010);
    tick();
    chk("ar_own1b", 32'(gnt_a), 32'b0010);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_gnt", 32'(gnt_a), 32'd0);
    chk("ar_oe_n", 32'(oe_n_a), 32'hf);
    chk("ar_idle", 32'(idle_a), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("ar_restart", 32'(gnt_a), 32'd1);
    chk("ar_restart_own", 32'(owner_a), 32'd0);

    // Randomized traffic against the behavioural model.
    do_reset();
    m_owner = -1;
    m_hold  = 0;
    m_gap   = 0;
    m_ptr   = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    r = 4'b0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      end
      req_a = r;
      model_step(r);
      exp_q.push_back((m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000);
      tick();
      e = exp_q.pop_front();
      chk("rand_gnt", 32'(gnt_a), 32'(e));
      if (e != 4'b0000) begin
        chk("rand_owner", 32'(owner_a), 32'(m_owner));
      end
      for (int i = 0; i < 4; i++) begin
        if (!r[i]) begin
          wait_cnt[i] = 0;
        end else if (gnt_a[i]) begin
          if (wait_cnt[i] > 0) chk($sformatf("starve%0d", i), 32'(wait_cnt[i] <= BOUND), 32'd1);
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
          if (wait_cnt[i] > BOUND) begin
            chk($sformatf("starve%0d", i), 32'(wait_cnt[i]), 32'(BOUND));
            wait_cnt[i] = 0;
          end
        end
      end
    end

    req_a = '0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
